// File: rtl/vn_mem_arbiter.sv
// vn_mem_arbiter: round-robin arbiter sharing one synchronous-read memory between CPU (port 0) and loader/debug (port 1)
// Ports: clk, rst (async active-low); per port pN_req/addr/wr_ena/wr_data in, pN_gnt/ack/rd_data out;
// mem_addr/mem_wr_data/mem_wr_ena out, mem_rd_data in; owner = port currently or last served, busy = not idle.
module vn_mem_arbiter #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         p0_req,
  input  logic [N-1:0] p0_addr,
  input  logic         p0_wr_ena,
  input  logic [N-1:0] p0_wr_data,
  output logic         p0_gnt,
  output logic         p0_ack,
  output logic [N-1:0] p0_rd_data,
  input  logic         p1_req,
  input  logic [N-1:0] p1_addr,
  input  logic         p1_wr_ena,
  input  logic [N-1:0] p1_wr_data,
  output logic         p1_gnt,
  output logic         p1_ack,
  output logic [N-1:0] p1_rd_data,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wr_data,
  output logic         mem_wr_ena,
  input  logic [N-1:0] mem_rd_data,
  output logic         owner,
  output logic         busy
);
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;
  state_t state, state_nx;
  logic last, wr_flag, win, any_req;
  assign any_req = p0_req | p1_req;
  // on a tie the port that was not served last wins
  assign win = (p0_req & p1_req) ? ~last : p1_req;
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = IDLE;
    p0_gnt = 1'b0;
    p1_gnt = 1'b0;
    p0_ack = 1'b0;
    p1_ack = 1'b0;
    mem_wr_ena = 1'b0;
    case (state)
      IDLE: state_nx = any_req ? ACCESS : IDLE;
      ACCESS: begin
        state_nx = WAIT;
        p0_gnt = ~owner;
        p1_gnt = owner;
        mem_wr_ena = wr_flag;
      end
      WAIT: state_nx = DONE;
      DONE: begin
        p0_ack = ~owner;
        p1_ack = owner;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      last <= 1'b1;
      owner <= 1'b0;
      wr_flag <= 1'b0;
      mem_addr <= '0;
      mem_wr_data <= '0;
      p0_rd_data <= '0;
      p1_rd_data <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        last <= win;
        owner <= win;
        mem_addr <= win ? p1_addr : p0_addr;
        mem_wr_data <= win ? p1_wr_data : p0_wr_data;
        wr_flag <= win ? p1_wr_ena : p0_wr_ena;
      end
      // memory data for the address registered in ACCESS is valid during WAIT
      if (state == WAIT && !wr_flag) begin
        if (owner) p1_rd_data <= mem_rd_data;
        else p0_rd_data <= mem_rd_data;
      end
    end
endmodule

// File: tb/tb_vn_mem_arbiter.sv
// tb_vn_mem_arbiter: directed self-checking bench for vn_mem_arbiter with a synchronous-read memory model
module tb_vn_mem_arbiter;
  logic clk = 1'b0, rst = 1'b0;
  logic p0_req = 1'b0, p0_wr_ena = 1'b0, p1_req = 1'b0, p1_wr_ena = 1'b0;
  logic [31:0] p0_addr = '0, p0_wr_data = '0, p1_addr = '0, p1_wr_data = '0;
  logic p0_gnt, p0_ack, p1_gnt, p1_ack, mem_wr_ena, owner, busy;
  logic [31:0] p0_rd_data, p1_rd_data, mem_addr, mem_wr_data;
  logic [31:0] mem_rd_data = '0;
  logic [31:0] mem [0:255];
  int n_vec = 0, n_err = 0, acks;
  vn_mem_arbiter #(.N(32)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_wr_ena(p0_wr_ena), .p0_wr_data(p0_wr_data),
    .p0_gnt(p0_gnt), .p0_ack(p0_ack), .p0_rd_data(p0_rd_data),
    .p1_req(p1_req), .p1_addr(p1_addr), .p1_wr_ena(p1_wr_ena), .p1_wr_data(p1_wr_data),
    .p1_gnt(p1_gnt), .p1_ack(p1_ack), .p1_rd_data(p1_rd_data),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_wr_ena(mem_wr_ena),
    .mem_rd_data(mem_rd_data), .owner(owner), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (mem_wr_ena) mem[mem_addr[7:0]] <= mem_wr_data;
    mem_rd_data <= mem[mem_addr[7:0]];
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk)
    if (rst) chk("excl", {29'd0, p0_gnt & p1_gnt, p0_ack & p1_ack, (p0_gnt | p1_gnt) & (p0_ack | p1_ack)}, 32'd0);
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h20] = 32'h1234;
    p0_req = 1'b1; p0_wr_ena = 1'b1; p0_addr = 32'h10; p0_wr_data = 32'hDEADBEEF;
    tick; tick;
    chk("rst_out", {26'd0, p0_gnt, p0_ack, p1_gnt, p1_ack, mem_wr_ena, busy}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_rd0", p0_rd_data, 32'd0);
    rst = 1'b1;
    chk("rel_c1_gnt", {30'd0, p0_gnt, busy}, 32'd0);
    tick;
    chk("wr_gnt", {28'd0, p0_gnt, p1_gnt, mem_wr_ena, owner}, 32'b1010);
    chk("wr_addr", mem_addr, 32'h10);
    chk("wr_data", mem_wr_data, 32'hDEADBEEF);
    tick;
    chk("wr_wait", {29'd0, mem_wr_ena, p0_gnt, p0_ack}, 32'd0);
    tick;
    chk("wr_ack", {31'd0, p0_ack}, 32'd1);
    tick;
    p0_wr_ena = 1'b0; p0_wr_data = 32'h0;
    tick;
    chk("rd_gnt", {30'd0, p0_gnt, mem_wr_ena}, 32'b10);
    tick; tick;
    chk("rd_ack", {31'd0, p0_ack}, 32'd1);
    chk("rd_data", p0_rd_data, 32'hDEADBEEF);
    tick;
    p0_req = 1'b0;
    p1_req = 1'b1; p1_addr = 32'h20; p1_wr_ena = 1'b0;
    tick;
    chk("p1_gnt", {29'd0, p0_gnt, p1_gnt, owner}, 32'b011);
    chk("p1_addr", mem_addr, 32'h20);
    tick;
    p1_addr = 32'h30;
    #1 chk("p1_hold_w", mem_addr, 32'h20);
    tick;
    chk("p1_hold_d", mem_addr, 32'h20);
    chk("p1_ack", {30'd0, p0_ack, p1_ack}, 32'b01);
    chk("p1_rd", p1_rd_data, 32'h1234);
    chk("p0_keep", p0_rd_data, 32'hDEADBEEF);
    tick;
    p1_req = 1'b0;
    p0_req = 1'b1; p0_wr_ena = 1'b1; p0_addr = 32'h40; p0_wr_data = 32'h55;
    tick;
    chk("drop_gnt", {31'd0, p0_gnt}, 32'd1);
    p0_req = 1'b0;
    tick; tick;
    chk("drop_ack", {31'd0, p0_ack}, 32'd1);
    tick;
    chk("drop_idle", {31'd0, busy}, 32'd0);
    tick;
    chk("drop_stay", {30'd0, busy, p0_gnt}, 32'd0);
    chk("wr_norddata", p0_rd_data, 32'hDEADBEEF);
    chk("mem_wr40", mem[8'h40], 32'h55);
    rst = 1'b0;
    p0_wr_ena = 1'b0; p0_addr = 32'h10; p1_wr_ena = 1'b0; p1_addr = 32'h20;
    p0_req = 1'b1; p1_req = 1'b1;
    tick;
    chk("rst2_rd", p0_rd_data | p1_rd_data, 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("tie_gnt", {30'd0, p0_gnt, p1_gnt}, (i % 2 == 0) ? 32'b10 : 32'b01);
      tick; tick;
      chk("tie_ack", {30'd0, p0_ack, p1_ack}, (i % 2 == 0) ? 32'b10 : 32'b01);
      chk("tie_rd", (i % 2 == 0) ? p0_rd_data : p1_rd_data, (i % 2 == 0) ? 32'hDEADBEEF : 32'h1234);
      tick;
      chk("tie_idle", {31'd0, busy}, 32'd0);
    end
    p1_req = 1'b0;
    tick;
    chk("mid_gnt", {31'd0, p0_gnt}, 32'd1);
    tick;
    rst = 1'b0;
    p0_req = 1'b0;
    #1;
    chk("mid_rst_out", {27'd0, p0_gnt, p0_ack, mem_wr_ena, busy, owner}, 32'd0);
    chk("mid_rst_addr", mem_addr, 32'd0);
    chk("mid_rst_rd", p0_rd_data | p1_rd_data, 32'd0);
    tick;
    rst = 1'b1;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      tick;
      acks += int'(p0_ack | p1_ack);
    end
    chk("mid_no_ack", acks, 32'd0);
    chk("mid_idle", {31'd0, busy}, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/vn_mem_arbiter.md
# vn_mem_arbiter

Single-port memory arbiter for the von Neumann multicycle CPU. It shares one synchronous-read unified instruction/data memory between two requesters:
- port 0: CPU memory interface (fetch and load/store);
- port 1: program loader / debug port.

Each access is sequenced through a fixed four-state FSM, with round-robin arbitration and a per-port request/grant/acknowledge handshake.

## Interface
- N, 32, address and data width
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-low reset
- p0_req  in  1  port 0 access request; held until p0_ack
- p0_addr  in  N  port 0 address
- p0_wr_ena  in  1  port 0: 1 = write, 0 = read
- p0_wr_data  in  N  port 0 write data
- p0_gnt  out  1  port 0 granted; one-cycle pulse in ACCESS
- p0_ack  out  1  port 0 access complete; one-cycle pulse in DONE
- p0_rd_data  out  N  port 0 read data; valid from p0_ack, held until the next port 0 read completes
- p1_req, p1_addr, p1_wr_ena, p1_wr_data, p1_gnt, p1_ack, p1_rd_data: same as port 0, for port 1
- mem_addr  out  N  memory address
- mem_wr_data  out  N  memory write data
- mem_wr_ena  out  1  memory write strobe
- mem_rd_data  in  N  memory read data; valid one cycle after mem_addr
- owner  out  1  port currently or last served
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, ACCESS, WAIT, DONE. Any other encoding returns to IDLE.
- IDLE:
  - If any req is high, select a winner and latch its addr, wr_ena and wr_data into mem_addr, mem_wr_data and the write flag.
  - Set owner to the winner and go to ACCESS.
  - With no req, stay in IDLE.
- Round-robin selection:
  - Only one req high: that port wins.
  - Both high: the port not in `last` wins.
  - `last` is updated to the winner when entering ACCESS; its reset value is 1, so port 0 wins the first tie.
- ACCESS:
  - The winner's gnt = 1.
  - mem_wr_ena = the latched write flag; it is never high in any other state.
  - Next state is WAIT.
- WAIT:
  - mem_addr is still held.
  - On a read, capture mem_rd_data into the winner's rd_data at the end of WAIT; the other port's rd_data is untouched.
  - Next state is DONE.
- DONE:
  - The winner's ack = 1.
  - req is ignored in this state.
  - Next state is IDLE.
- Latched values:
  - mem_addr and mem_wr_data keep their latched values from ACCESS until the next grant.
  - Requester inputs that change after the latch have no effect on the current transaction.
- A req dropped mid-transaction does not abort it: the transaction completes and ack still pulses.
- A writing port's rd_data is not modified.

## Timing
- Reset (rst low, asynchronous):
  - state = IDLE, last = 1, owner = 0, busy = 0.
  - All gnt, ack and mem_wr_ena = 0; mem_addr, mem_wr_data and both rd_data = 0.
  - An in-flight transaction is dropped with no ack.
  - Release is sampled at the next rising clk.
- Latency, with req high in IDLE cycle t:
  - gnt in cycle t+1;
  - memory write, or read address registered by the memory, at the end of t+1;
  - ack and valid rd_data in cycle t+3.
- Throughput: one access per 4 cycles for a continuously requesting single port.
  - Back-to-back with both ports requesting: grants alternate p0, p1, p0, …
- Requester rule: present a new addr/wr_ena/wr_data, or drop req, in the cycle after ack. A req still high in the next IDLE cycle starts a new transaction.
- gnt and ack are never high on both ports in the same cycle. gnt and ack never overlap.
- Simultaneous requests arriving in DONE are evaluated in the following IDLE cycle.

## Test plan
- Reset: hold rst low with p0_req = 1 → all outputs 0 and busy = 0; after release, p0_gnt appears in the 2nd cycle.
- Port 0 write then read:
  - p0 write addr 0x10, data 0xDEADBEEF → mem_wr_ena high for exactly one cycle with mem_addr = 0x10, and p0_ack 2 cycles after p0_gnt.
  - Then read 0x10 → p0_rd_data = 0xDEADBEEF with p0_ack, 3 cycles after the req cycle.
- Tie-break: p0_req and p1_req asserted together from reset and held for 4 transactions → grant order p0, p1, p0, p1, each access 4 cycles apart.
- Isolation:
  - p1 reads 0x20 (memory holds 0x1234) while p0 holds rd_data 0xDEADBEEF → p1_rd_data = 0x1234 and p0_rd_data unchanged.
  - Changing p1_addr during WAIT does not change mem_addr.
- Drop mid-flight: deassert p0_req in ACCESS → p0_ack still pulses in DONE; FSM returns to IDLE and stays there, busy = 0.
- Reset mid-operation: pull rst low during WAIT → outputs 0 immediately (before the next clk) and no ack after release.
